calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Two-operand decimal add/subtract sequencer driven by debounced keypad events.
// A delayed key sample feeds an A/OP/B/RES state machine with registered display outputs.
module calc_sequencer #(
  parameter int KEY_DLY = 50002,
  parameter int MAX_DIG = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        any_btn,
  input  logic        is_number,
  input  logic        is_op,
  input  logic        is_eq,
  input  logic [3:0]  num_val,
  input  logic [1:0]  op_val,
  output logic [14:0] disp_val,
  output logic        disp_neg,
  output logic [1:0]  state_o,
  output logic        result_valid,
  output logic        key_evt
);

  localparam int DW    = $clog2(KEY_DLY + 1);
  localparam int LIMIT = 10 ** (MAX_DIG - 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_OP  = 2'd1,
    S_B   = 2'd2,
    S_RES = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] dly;
  logic          armed;
  logic          counting;

  logic          smp_num;
  logic          smp_op;
  logic          smp_eq;
  logic [3:0]    smp_num_val;
  logic [1:0]    smp_op_val;

  logic [13:0]   a;
  logic [13:0]   b;
  logic [14:0]   r;
  logic          op_minus;

  logic          one_hot;
  logic          dig_key;
  logic          op_key;
  logic          eq_key;
  logic          new_minus;
  logic [14:0]   calc;
  logic [14:0]   r_abs;
  logic          r_fits;
  logic [13:0]   a_app;
  logic [13:0]   b_app;

  function automatic logic [13:0] append(input logic [13:0] acc, input logic [3:0] d);
    if (int'(acc) < LIMIT)
      return acc * 14'd10 + {10'b0, d};
    return acc;
  endfunction

  // armed is only set while any_btn is low, so a held key cannot re-trigger
  // and a key already held across reset release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly         <= '0;
      armed       <= 1'b0;
      counting    <= 1'b0;
      key_evt     <= 1'b0;
      smp_num     <= 1'b0;
      smp_op      <= 1'b0;
      smp_eq      <= 1'b0;
      smp_num_val <= '0;
      smp_op_val  <= '0;
    end else begin
      key_evt <= 1'b0;
      if (!any_btn) begin
        armed    <= 1'b1;
        counting <= 1'b0;
        dly      <= '0;
      end else if (counting) begin
        if (dly == DW'(KEY_DLY - 1)) begin
          key_evt     <= 1'b1;
          smp_num     <= is_number;
          smp_op      <= is_op;
          smp_eq      <= is_eq;
          smp_num_val <= num_val;
          smp_op_val  <= op_val;
          counting    <= 1'b0;
          armed       <= 1'b0;
          dly         <= '0;
        end else begin
          dly <= dly + 1'b1;
        end
      end else if (armed) begin
        counting <= 1'b1;
        dly      <= '0;
      end
    end
  end

  always_comb begin
    one_hot   = (smp_num & ~smp_op & ~smp_eq) |
                (~smp_num & smp_op & ~smp_eq) |
                (~smp_num & ~smp_op & smp_eq);
    dig_key   = key_evt & one_hot & smp_num & (smp_num_val <= 4'd9);
    op_key    = key_evt & one_hot & smp_op & ((smp_op_val == 2'd1) | (smp_op_val == 2'd2));
    eq_key    = key_evt & one_hot & smp_eq;
    new_minus = (smp_op_val == 2'd2);
    calc      = op_minus ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r_abs     = r[14] ? (~r + 15'd1) : r;
    r_fits    = !r[14] && (r <= 15'd9999);
    a_app     = append(a, smp_num_val);
    b_app     = append(b, smp_num_val);
  end

  // Display is registered from the current operand state, so it trails the
  // state register by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_A;
      a            <= '0;
      b            <= '0;
      r            <= '0;
      op_minus     <= 1'b0;
      result_valid <= 1'b0;
      disp_val     <= '0;
      disp_neg     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_RES:   begin disp_val <= r_abs;      disp_neg <= r[14]; end
        S_B:     begin disp_val <= {1'b0, b};  disp_neg <= 1'b0;  end
        default: begin disp_val <= {1'b0, a};  disp_neg <= 1'b0;  end
      endcase

      case (state)
        S_A: begin
          if (dig_key) begin
            a <= a_app;
          end else if (op_key) begin
            op_minus <= new_minus;
            state    <= S_OP;
          end
        end
        S_OP: begin
          if (dig_key) begin
            b     <= {10'b0, smp_num_val};
            state <= S_B;
          end else if (op_key) begin
            op_minus <= new_minus;
          end
        end
        S_B: begin
          if (dig_key) begin
            b <= b_app;
          end else if (eq_key) begin
            r            <= calc;
            result_valid <= 1'b1;
            state        <= S_RES;
          end
        end
        S_RES: begin
          if (dig_key) begin
            a     <= {10'b0, smp_num_val};
            b     <= '0;
            state <= S_A;
          end else if (op_key && r_fits) begin
            a        <= r[13:0];
            op_minus <= new_minus;
            state    <= S_OP;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign state_o = state;

endmodule
